// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic valid/ready register chain of DEPTH stages.
// Empty stages always accept, so a stall at the output only blocks the
// input once every stage holds a beat. Flush clears all stages on the next
// edge and refuses the beat offered in the same cycle. Occupancy is kept as
// a registered up/down count of input and output transfers.
module pipe_reg_chain #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // Stage state; index 0 is the input end, DEPTH-1 drives the outputs.
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Per-stage ready and the beat each stage would take if it advances.
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];

  logic in_xfer;
  logic out_xfer;

  // Ready chain, unrolled: a stage may advance when downstream accepts or
  // when any stage from itself to the output end is empty. This is the
  // recursive rule rdy[i] = !valid[i] || rdy[i+1] written without a
  // self-referencing vector, so the out_ready path stays a clean cone.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!valid_q[j]) begin
          rdy[i] = 1'b1;
        end
      end
    end
  end

  // Source of each stage: stage 0 takes the input port, the rest take the
  // stage in front of them.
  always_comb begin
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_valid[i] = valid_q[i-1];
      up_data[i]  = data_q[i-1];
    end
  end

  // Handshake view at the chain boundaries.
  always_comb begin
    in_ready  = rdy[0] && !flush;
    out_valid = valid_q[DEPTH-1];
    out_data  = data_q[DEPTH-1];
    occupancy = occ_q;
    in_xfer   = in_valid && in_ready;
    out_xfer  = valid_q[DEPTH-1] && out_ready;
  end

  // Next stage state: flush wins; otherwise ready stages shift forward and
  // data is only overwritten by a valid incoming beat, so an empty stage
  // keeps its last payload.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          valid_d[i] = up_valid[i];
          if (up_valid[i]) begin
            data_d[i] = up_data[i];
          end
        end
      end
    end
  end

  // Occupancy tracks transfers; simultaneous in and out cancel out.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (WIDTH=32, DEPTH=3,
// RESET_VAL=0xDEADBEEF): directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_pipe_reg_chain;

  localparam int          W  = 32;
  localparam int          D  = 3;
  localparam logic [31:0] RV = 32'hDEADBEEF;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: ordered queue of beats, each tagged with the stage
  // position it currently sits in.
  typedef struct {
    logic [31:0] data;
    int          pos;
  } beat_t;

  beat_t       mq[$];
  logic [31:0] m_last;

  function automatic void mdl_reset();
    mq.delete();
    m_last = RV;
  endfunction

  function automatic logic m_out_valid();
    return (mq.size() > 0) && (mq[0].pos == D - 1);
  endfunction

  function automatic logic m_in_ready(input logic f, input logic ordy);
    return !f && (ordy || (mq.size() < D));
  endfunction

  // One clock edge: deliver the head if it leaves, then every beat moves
  // up one position if the slot above it is free after the beats ahead of
  // it have moved, then the accepted input beat enters at position 0.
  function automatic void mdl_edge(input logic f, input logic iv,
                                   input logic [31:0] id, input logic ordy);
    logic  acc;
    int    ceiling;
    int    np;
    beat_t b;
    if (f) begin
      mdl_reset();
    end else begin
      acc = iv && m_in_ready(1'b0, ordy);
      if (m_out_valid() && ordy) void'(mq.pop_front());
      ceiling = D - 1;
      for (int i = 0; i < mq.size(); i++) begin
        b  = mq[i];
        np = (b.pos + 1 <= ceiling) ? b.pos + 1 : b.pos;
        if (np == D - 1 && b.pos != D - 1) m_last = b.data;
        b.pos   = np;
        mq[i]   = b;
        ceiling = np - 1;
      end
      if (acc) begin
        b.data = id;
        b.pos  = 0;
        if (D - 1 == 0) m_last = id;
        mq.push_back(b);
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  typedef struct {
    logic        f;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    int          e_occ;
  } vec_t;

  vec_t tbl[22];

  // Called just after a rising edge: drive inputs, sample mid-cycle,
  // then advance over the next edge keeping the model in step.
  task automatic step(input logic f, input logic iv, input logic [31:0] d,
                      input logic ordy, input bit use_tbl, input vec_t e,
                      input string tag);
    flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #3;
    if (use_tbl) begin
      chk({tag, ".in_ready"},  32'(in_ready),  32'(e.e_ir));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(e.e_ov));
      chk({tag, ".out_data"},  out_data,       e.e_od);
      chk({tag, ".occupancy"}, 32'(occupancy), 32'(e.e_occ));
    end else begin
      chk({tag, ".in_ready"},  32'(in_ready),  32'(m_in_ready(f, ordy)));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_out_valid()));
      chk({tag, ".out_data"},  out_data,       m_last);
      chk({tag, ".occupancy"}, 32'(occupancy), 32'(mq.size()));
    end
    @(posedge clk);
    mdl_edge(f, iv, d, ordy);
    #1;
  endtask

  vec_t none;
  int   acc_n;
  int   del_n;

  initial begin
    none = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0};
    // flush, iv, data, out_ready | in_ready, out_valid, out_data, occupancy
    tbl[0]  = '{1'b0, 1'b1, 32'h1,  1'b0, 1'b1, 1'b0, RV,       0};
    tbl[1]  = '{1'b0, 1'b1, 32'h2,  1'b0, 1'b1, 1'b0, RV,       1};
    tbl[2]  = '{1'b0, 1'b1, 32'h3,  1'b0, 1'b1, 1'b0, RV,       2};
    tbl[3]  = '{1'b0, 1'b1, 32'h4,  1'b0, 1'b0, 1'b1, 32'h1,    3};
    tbl[4]  = '{1'b0, 1'b1, 32'h4,  1'b0, 1'b0, 1'b1, 32'h1,    3};
    tbl[5]  = '{1'b0, 1'b1, 32'h4,  1'b1, 1'b1, 1'b1, 32'h1,    3};
    tbl[6]  = '{1'b0, 1'b0, 32'h5,  1'b0, 1'b0, 1'b1, 32'h2,    3};
    tbl[7]  = '{1'b1, 1'b1, 32'h99, 1'b1, 1'b0, 1'b1, 32'h2,    3};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, RV,       0};
    tbl[9]  = '{1'b0, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, RV,       0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, RV,       1};
    tbl[11] = '{1'b0, 1'b1, 32'hB0, 1'b0, 1'b1, 1'b0, RV,       1};
    tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hA0,   2};
    tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hA0,   2};
    tbl[14] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA0,   2};
    tbl[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB0,   1};
    tbl[16] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'hB0,   0};
    tbl[17] = '{1'b0, 1'b1, 32'hC1, 1'b0, 1'b1, 1'b0, 32'hB0,   0};
    tbl[18] = '{1'b0, 1'b1, 32'hC2, 1'b0, 1'b1, 1'b0, 32'hB0,   1};
    tbl[19] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'hB0,   2};
    tbl[20] = '{1'b1, 1'b1, 32'hEE, 1'b1, 1'b0, 1'b1, 32'hC1,   2};
    tbl[21] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, RV,       0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mdl_reset();
    @(posedge clk); #1;
    chk("por.out_valid", 32'(out_valid), 32'd0);
    chk("por.out_data",  out_data,       RV);
    chk("por.occupancy", 32'(occupancy), 32'd0);
    chk("por.in_ready",  32'(in_ready),  32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Streaming 0x1..0xA back-to-back with out_ready high.
    for (int c = 0; c < 14; c++) begin
      flush = 1'b0; out_ready = 1'b1;
      in_valid = (c < 10); in_data = 32'(c + 1);
      #3;
      acc_n = (c < 10) ? c : 10;
      del_n = (c < 3) ? 0 : ((c - 3 < 10) ? c - 3 : 10);
      chk("stream.in_ready",  32'(in_ready),  32'd1);
      chk("stream.out_valid", 32'(out_valid), 32'(c >= 3 && c < 13));
      if (c >= 3 && c < 13) chk("stream.out_data", out_data, 32'(c - 2));
      chk("stream.occupancy", 32'(occupancy), 32'(acc_n - del_n));
      @(posedge clk);
      mdl_edge(flush, in_valid, in_data, out_ready);
      #1;
    end

    // Asynchronous reset pulse away from any edge.
    in_valid = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b1;
    mdl_reset();
    #1;
    chk("areset.out_valid", 32'(out_valid), 32'd0);
    chk("areset.out_data",  out_data,       RV);
    chk("areset.occupancy", 32'(occupancy), 32'd0);
    chk("areset.in_ready",  32'(in_ready),  32'd1);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Backpressure/fill, flush at full, bubble collapse, flush at two beats.
    for (int r = 0; r < 22; r++) begin
      step(tbl[r].f, tbl[r].iv, tbl[r].d, tbl[r].ordy, 1'b1, tbl[r], $sformatf("vec%0d", r));
    end

    // Reset while full and stalled, then a fresh beat must see an empty chain.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h11 + 32'(i), 1'b0, 1'b0, none, "fill");
    in_valid = 1'b0;
    reset = 1'b1;
    mdl_reset();
    #3;
    chk("rstmid.out_valid", 32'(out_valid), 32'd0);
    chk("rstmid.out_data",  out_data,       RV);
    chk("rstmid.occupancy", 32'(occupancy), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      flush = 1'b0; out_ready = 1'b1; in_valid = (c == 0); in_data = 32'h55;
      #3;
      chk("rstmid.lat_valid", 32'(out_valid), 32'(c == 3));
      chk("rstmid.lat_data",  out_data, (c >= 3) ? 32'h55 : RV);
      chk("rstmid.lat_occ",   32'(occupancy), 32'(c >= 1 && c <= 3));
      @(posedge clk);
      mdl_edge(flush, in_valid, in_data, out_ready);
      #1;
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70), $urandom,
           ($urandom_range(0, 99) < 55), 1'b0, none, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised elastic pipeline register: a chain of DEPTH valid/ready stages carrying a WIDTH-bit payload, with per-stage hold (stall), bubble collapsing, synchronous flush and an occupancy count. It generalises the plain and enable-gated flop registers. It is the standard inter-stage register for the MIPS datapath (IF/ID, ID/EX, ...), where hazard logic drives `flush` and downstream stalls drive `out_ready`.

## Interface
- `WIDTH`, default 32: payload width in bits, at least 1.
- `DEPTH`, default 2: number of register stages, at least 1.
- `RESET_VAL`, default 0: WIDTH-bit value loaded into every stage's data on reset or flush.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: reset, asynchronous, active-high.
- `flush`  in  1: synchronous clear of all stages. Has priority over all loads.
- `in_valid`  in  1: upstream beat present.
- `in_ready`  out  1: chain accepts a beat this cycle.
- `in_data`  in  WIDTH: upstream payload.
- `out_valid`  out  1: last stage holds a beat.
- `out_ready`  in  1: downstream accepts a beat.
- `out_data`  out  WIDTH: last-stage payload.
- `occupancy`  out  $clog2(DEPTH+1): number of valid stages.

## Operation
- Stage state: `valid[i]` and `data[i]` for i = 0..DEPTH-1. Stage 0 is the input end; stage DEPTH-1 drives `out_valid` and `out_data`.
- Ready chain (combinational):
  - `rdy[DEPTH] = out_ready`.
  - `rdy[i] = !valid[i] || rdy[i+1]`.
  - `in_ready = rdy[0] && !flush`.
- Bubble collapsing: an empty stage always accepts, so a stall at the output does not block the upstream stages until the chain is full.
- Stage i advances when `rdy[i]` is 1 and flush is 0:
  - `valid[i] <= valid[i-1]`; stage 0 takes `in_valid`.
  - `data[i] <= data[i-1]`; stage 0 takes `in_data`.
  - `data[i]` is written only when the incoming valid is 1. Otherwise data holds and only valid clears.
- A stage with `rdy[i]` equal to 0 holds both valid and data.
- Transfers:
  - Input transfer: `in_valid && in_ready`.
  - Output transfer: `out_valid && out_ready`. This is legal in the flush cycle and counts as delivered.
- Flush: on the next edge every `valid[i]` goes to 0 and every `data[i]` goes to RESET_VAL. Any beat presented at the input in the flush cycle is not accepted, because `in_ready` is 0.
- Occupancy:
  - Registered.
  - Updates by +1 on an input transfer, -1 on an output transfer, and is unchanged when both or neither occur.
  - Goes to 0 on flush.
  - Always equals popcount(valid).
- `out_data` while `out_valid` is 0 is the last value held by the stage: RESET_VAL after reset or flush, otherwise the last loaded beat. Consumers must not rely on it.
- Order is strictly preserved. No beat is duplicated or dropped except by flush.

## Timing
- Reset values, held while `reset` is high and regardless of clk:
  - all `valid` = 0 and all `data` = RESET_VAL;
  - `out_valid` = 0, `out_data` = RESET_VAL, `occupancy` = 0;
  - `in_ready` = 1 unless `flush` is high.
- Reset asserted mid-stream discards all beats immediately. The first edge after deassertion behaves as an empty chain.
- Latency: a beat accepted at edge N appears on `out_valid` after edge N+DEPTH-1, i.e. it is valid in the cycle following DEPTH edges including the accept edge, provided `out_ready` stays high. Minimum in-to-out is DEPTH cycles.
- Throughput: 1 beat per cycle with `out_ready` held high.
- Full chain (occupancy = DEPTH) with `out_ready` = 1: `in_ready` = 1 in the same cycle (pass-through of the ready chain). No one-cycle bubble.
- Full chain with `out_ready` = 0: `in_ready` = 0.
- Combinational paths:
  - `out_ready` to `in_ready` (DEPTH levels);
  - `flush` to `in_ready`.
- No path from `in_valid` or `in_data` to any output.
- Flush and reset are the only ways to clear beats. Flush with an empty chain is a no-op apart from data returning to RESET_VAL.

## Test plan
- Reset check: WIDTH=32, DEPTH=3, RESET_VAL=0xDEADBEEF, reset pulsed mid-clock -> `out_valid`=0, `out_data`=0xDEADBEEF, `occupancy`=0, `in_ready`=1, all asynchronous.
- Streaming: 10 beats 0x1..0xA back-to-back with `out_ready`=1 and DEPTH=3 -> first `out_valid` 3 cycles after the first accept, then 0x1..0xA on consecutive cycles, and `occupancy` steady at 3.
- Backpressure and fill: `out_ready`=0 while 5 beats are offered -> exactly 3 accepted, `in_ready` drops after the third, `occupancy`=3. Raising `out_ready` for 1 cycle -> 0x1 delivered and 0x4 accepted in the same cycle, with `occupancy` staying 3.
- Bubble collapse: beat A, idle 1 cycle, beat B, with `out_ready`=0 -> both held, `occupancy`=2, `in_ready`=1. Releasing `out_ready` -> A then B on consecutive cycles.
- Flush mid-stream: occupancy 2, and in the flush cycle `in_valid`=1 and `out_ready`=1 -> the output beat counts as delivered, the input beat is refused (`in_ready`=0), and next cycle `occupancy`=0, `out_valid`=0, `out_data`=RESET_VAL.
- Reset mid-operation: chain full with `out_ready`=0, then reset asserted for 2 cycles -> all beats lost. After deassertion a new beat 0x55 appears after exactly DEPTH cycles, with no stale data.
